// File: rtl/edge_level_regen_pkg.sv
// Shared types and helpers for the edge-to-level regenerator.
// The dwell counter width is derived here so the top and the timer agree on it.
package edge_level_regen_pkg;

   typedef enum logic [1:0] {LOW, HOLD_HIGH, HIGH, HOLD_LOW} regen_state_t;

   function automatic int cntWidth(input int minHold);
      return (minHold < 1) ? 1 : $clog2(minHold + 1);
   endfunction

endpackage

// File: rtl/edge_level_regen_dwell_timer.sv
// Dwell timer: loads MIN_HOLD-1 on a level transition and counts down to zero.
// The zero flag marks the last cycle of the dwell.
module dwell_timer
   import edge_level_regen_pkg::*;
#(
   parameter int MIN_HOLD = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_load,
   input  logic i_dec,
   output logic o_zero
);

   localparam int CNT_W = cntWidth(MIN_HOLD);
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(MIN_HOLD - 1);
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [CNT_W-1:0] r_count;

   // Load wins over decrement so a fresh transition always restarts the full dwell.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= RELOAD;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - ONE;
      end
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/edge_level_regen.sv
// Rebuilds a glitch-free level from rise/fall event pulses with a minimum dwell per level.
// Define EDGE_LEVEL_REGEN_ECHO_EN to add rise_echo_o/fall_echo_o loop-back pulses.
module edge_level_regen
   import edge_level_regen_pkg::*;
#(
   parameter int   MIN_HOLD   = 4,
   parameter logic INIT_LEVEL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic rise_i,
   input  logic fall_i,
   output logic a_o,
   output logic busy_o,
   output logic pend_o,
`ifdef EDGE_LEVEL_REGEN_ECHO_EN
   output logic rise_echo_o,
   output logic fall_echo_o,
`endif
   output logic err_o
);

   localparam regen_state_t RESET_STATE = INIT_LEVEL ? HIGH : LOW;

   regen_state_t r_state;
   regen_state_t w_stateNext;
   logic r_level, w_levelNext;
   logic r_busy, w_busyNext;
   logic r_pend, w_pendNext;
   logic r_err, w_errNext;
   logic w_load, w_dec, w_zero;
   logic w_both, w_riseOnly, w_fallOnly;

   assign w_both     = rise_i & fall_i;
   assign w_riseOnly = rise_i & ~fall_i;
   assign w_fallOnly = fall_i & ~rise_i;

   dwell_timer #(
      .MIN_HOLD (MIN_HOLD)
   ) u_dwell_timer (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_load),
      .i_dec  (w_dec),
      .o_zero (w_zero)
   );

   // Requests are arbitrated first; the dwell expiry then either applies the
   // surviving queued edge or settles. An edge newly queued on the last dwell
   // cycle keeps the hold state one more cycle so it is applied next cycle.
   always_comb begin
      w_stateNext = r_state;
      w_levelNext = r_level;
      w_pendNext  = r_pend;
      w_errNext   = 1'b0;
      w_load      = 1'b0;
      w_dec       = 1'b0;
      case (r_state)
         LOW: begin
            if (w_both || w_fallOnly) begin
               w_errNext = 1'b1;
            end else if (w_riseOnly) begin
               w_stateNext = HOLD_HIGH;
               w_levelNext = 1'b1;
               w_load      = 1'b1;
            end
         end
         HIGH: begin
            if (w_both || w_riseOnly) begin
               w_errNext = 1'b1;
            end else if (w_fallOnly) begin
               w_stateNext = HOLD_LOW;
               w_levelNext = 1'b0;
               w_load      = 1'b1;
            end
         end
         HOLD_HIGH: begin
            w_dec = 1'b1;
            if (w_both) begin
               w_errNext = 1'b1;
            end else if (w_riseOnly) begin
               if (r_pend) w_pendNext = 1'b0;
               else        w_errNext  = 1'b1;
            end else if (w_fallOnly) begin
               if (r_pend) w_errNext  = 1'b1;
               else        w_pendNext = 1'b1;
            end
            if (w_zero) begin
               if (r_pend && w_pendNext) begin
                  w_stateNext = HOLD_LOW;
                  w_levelNext = 1'b0;
                  w_pendNext  = 1'b0;
                  w_load      = 1'b1;
               end else if (!w_pendNext) begin
                  w_stateNext = HIGH;
               end
            end
         end
         HOLD_LOW: begin
            w_dec = 1'b1;
            if (w_both) begin
               w_errNext = 1'b1;
            end else if (w_fallOnly) begin
               if (r_pend) w_pendNext = 1'b0;
               else        w_errNext  = 1'b1;
            end else if (w_riseOnly) begin
               if (r_pend) w_errNext  = 1'b1;
               else        w_pendNext = 1'b1;
            end
            if (w_zero) begin
               if (r_pend && w_pendNext) begin
                  w_stateNext = HOLD_HIGH;
                  w_levelNext = 1'b1;
                  w_pendNext  = 1'b0;
                  w_load      = 1'b1;
               end else if (!w_pendNext) begin
                  w_stateNext = LOW;
               end
            end
         end
         default: begin
            w_stateNext = RESET_STATE;
            w_levelNext = INIT_LEVEL;
            w_pendNext  = 1'b0;
         end
      endcase
      w_busyNext = (w_stateNext == HOLD_HIGH) || (w_stateNext == HOLD_LOW);
   end

`ifdef EDGE_LEVEL_REGEN_ECHO_EN
   logic r_riseEcho, r_fallEcho;

   // Echo pulses coincide with the registered level change they describe.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_riseEcho <= 1'b0;
         r_fallEcho <= 1'b0;
      end else begin
         r_riseEcho <= w_levelNext & ~r_level;
         r_fallEcho <= ~w_levelNext & r_level;
      end
   end

   assign rise_echo_o = r_riseEcho;
   assign fall_echo_o = r_fallEcho;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= RESET_STATE;
         r_level <= INIT_LEVEL;
         r_busy  <= 1'b0;
         r_pend  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_stateNext;
         r_level <= w_levelNext;
         r_busy  <= w_busyNext;
         r_pend  <= w_pendNext;
         r_err   <= w_errNext;
      end
   end

   assign a_o    = r_level;
   assign busy_o = r_busy;
   assign pend_o = r_pend;
   assign err_o  = r_err;

endmodule

// File: tb/tb_edge_level_regen.sv
// Directed bench for edge_level_regen: MIN_HOLD=4/INIT_LEVEL=0 main instance and
// a MIN_HOLD=1/INIT_LEVEL=1 instance for the short-dwell boundary.
module tb_edge_level_regen;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rise = 1'b0, fall = 1'b0;
   logic rise2 = 1'b0, fall2 = 1'b0;
   logic a, busy, pend, err;
   logic a2, busy2, pend2, err2;
`ifdef EDGE_LEVEL_REGEN_ECHO_EN
   logic riseEcho, fallEcho, riseEcho2, fallEcho2;
   logic prevA;
`endif

   int checkCount = 0;
   int errorCount = 0;

   always #5 clk = ~clk;

   edge_level_regen #(.MIN_HOLD(4), .INIT_LEVEL(1'b0)) dut (
      .clk (clk), .rst (rst), .rise_i (rise), .fall_i (fall),
      .a_o (a), .busy_o (busy), .pend_o (pend),
`ifdef EDGE_LEVEL_REGEN_ECHO_EN
      .rise_echo_o (riseEcho), .fall_echo_o (fallEcho),
`endif
      .err_o (err)
   );

   edge_level_regen #(.MIN_HOLD(1), .INIT_LEVEL(1'b1)) dutShort (
      .clk (clk), .rst (rst), .rise_i (rise2), .fall_i (fall2),
      .a_o (a2), .busy_o (busy2), .pend_o (pend2),
`ifdef EDGE_LEVEL_REGEN_ECHO_EN
      .rise_echo_o (riseEcho2), .fall_echo_o (fallEcho2),
`endif
      .err_o (err2)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic observed, input logic expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %b expected %b", tag, observed, expected);
      end
   endtask

   // Drives one cycle of requests to the main instance and samples 1ns after the edge.
   task automatic applyStimulus(input logic r, input logic f);
      rise = r;
      fall = f;
      @(posedge clk);
      #1;
      rise = 1'b0;
      fall = 1'b0;
`ifdef EDGE_LEVEL_REGEN_ECHO_EN
      if (!rst) begin
         checkOutput("riseEcho", riseEcho, a & ~prevA);
         checkOutput("fallEcho", fallEcho, ~a & prevA);
      end
      prevA = a;
`endif
   endtask

   task automatic applyStimulusShort(input logic r, input logic f);
      rise2 = r;
      fall2 = f;
      @(posedge clk);
      #1;
      rise2 = 1'b0;
      fall2 = 1'b0;
   endtask

   task automatic checkMain(input string tag, input logic ea, input logic eb, input logic ep, input logic ee);
      checkOutput({tag, ".a"}, a, ea);
      checkOutput({tag, ".busy"}, busy, eb);
      checkOutput({tag, ".pend"}, pend, ep);
      checkOutput({tag, ".err"}, err, ee);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
`ifdef EDGE_LEVEL_REGEN_ECHO_EN
      prevA = 1'b0;
`endif
      rst = 1'b1;
      repeat (2) applyStimulus(1'b0, 1'b0);
      rst = 1'b0;
      checkMain("reset", 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("resetShort.a", a2, 1'b1);
      checkOutput("resetShort.busy", busy2, 1'b0);

      // Basic rise with full dwell, then settle in HIGH
      applyStimulus(1'b1, 1'b0);
      checkMain("t1.rise", 1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b0);
         checkMain("t1.dwell", 1'b1, 1'b1, 1'b0, 1'b0);
      end
      applyStimulus(1'b0, 1'b0);
      checkMain("t1.high", 1'b1, 1'b0, 1'b0, 1'b0);

      // Redundant rise while HIGH
      applyStimulus(1'b1, 1'b0);
      checkMain("t4.riseInHigh", 1'b1, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0);
      checkMain("t4.errClears", 1'b1, 1'b0, 1'b0, 1'b0);

      // Fall from HIGH back to LOW
      applyStimulus(1'b0, 1'b1);
      checkMain("fall.hold", 1'b0, 1'b1, 1'b0, 1'b0);
      repeat (3) applyStimulus(1'b0, 1'b0);
      checkMain("fall.lastDwell", 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
      checkMain("fall.low", 1'b0, 1'b0, 1'b0, 1'b0);

      // Queued fall applied exactly MIN_HOLD cycles after the rise
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1);
      checkMain("t2.pendSet", 1'b1, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
      checkMain("t2.stillHigh", 1'b1, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
      checkMain("t2.applied", 1'b0, 1'b1, 1'b0, 1'b0);
      repeat (3) applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
      checkMain("t2.low", 1'b0, 1'b0, 1'b0, 1'b0);

      // Pending fall cancelled by a later rise: no error, no glitch
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1);
      checkMain("t3.pend", 1'b1, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0);
      checkMain("t3.cancel", 1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
      checkMain("t3.dwell", 1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
      checkMain("t3.high", 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1);
      repeat (4) applyStimulus(1'b0, 1'b0);
      checkMain("t3.backLow", 1'b0, 1'b0, 1'b0, 1'b0);

      // Second fall while one is already pending is redundant
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1);
      checkMain("dupFall.err", 1'b1, 1'b1, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0);
      checkMain("dupFall.wait", 1'b1, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
      checkMain("dupFall.applied", 1'b0, 1'b1, 1'b0, 1'b0);
      repeat (4) applyStimulus(1'b0, 1'b0);
      checkMain("dupFall.low", 1'b0, 1'b0, 1'b0, 1'b0);

      // Simultaneous rise and fall while LOW
      applyStimulus(1'b1, 1'b1);
      checkMain("t4.both", 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0);
      checkMain("t4.bothAfter", 1'b0, 1'b0, 1'b0, 1'b0);

      // Reset during HOLD_HIGH with a pending fall drops everything
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1);
      checkMain("t6.pend", 1'b1, 1'b1, 1'b1, 1'b0);
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0);
      rst = 1'b0;
      checkMain("t6.reset", 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b0, 1'b0);
         checkMain("t6.quiet", 1'b0, 1'b0, 1'b0, 1'b0);
      end

      // MIN_HOLD=1 instance, starting HIGH
      applyStimulusShort(1'b0, 1'b1);
      checkOutput("short.fall.a", a2, 1'b0);
      checkOutput("short.fall.busy", busy2, 1'b1);
      applyStimulusShort(1'b1, 1'b0);
      checkOutput("short.queue.a", a2, 1'b0);
      checkOutput("short.queue.pend", pend2, 1'b1);
      checkOutput("short.queue.err", err2, 1'b0);
      applyStimulusShort(1'b0, 1'b0);
      checkOutput("short.apply.a", a2, 1'b1);
      checkOutput("short.apply.pend", pend2, 1'b0);
      checkOutput("short.apply.busy", busy2, 1'b1);
      applyStimulusShort(1'b0, 1'b0);
      checkOutput("short.high.a", a2, 1'b1);
      checkOutput("short.high.busy", busy2, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
